// File: rtl/regs_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter.
package regs_arb_pkg;

  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
  } rtag_t;

  typedef enum logic [1:0] {PORT_NONE, PORT_1, PORT_2} port_sel_t;

  function automatic logic [2:0] wrap_inc(input logic [2:0] i, input int nreq);
    if (i == 3'(nreq - 1)) return 3'd0;
    return i + 3'd1;
  endfunction

endpackage

// File: rtl/regs_port_arbiter_rr_pick.sv
// Circular first-one finder: lowest set mask bit at or after start_i, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] mask_i,
  input  logic [2:0]      start_i,
  output logic            found_o,
  output logic [2:0]      idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found_o && mask_i[i] && (3'(i) >= start_i)) begin
        found_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
    // Wrapped half of the scan: only reached when nothing was found upstream.
    for (int i = 0; i < NREQ; i++) begin
      if (!found_o && mask_i[i] && (3'(i) < start_i)) begin
        found_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/regs_port_arbiter.sv
// Two-port round-robin arbiter in front of the 32 x n register file.
// Slot A drives port 1, slot B drives port 2; read data returns one cycle later.
module regs_port_arbiter
  import regs_arb_pkg::*;
#(
  parameter int n    = 8,
  parameter int NREQ = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][REG_AW-1:0] req_addr,
  input  logic [NREQ-1:0][n-1:0]      req_wdata,
  output logic [NREQ-1:0]             gnt,
  output logic [NREQ-1:0]             rvalid,
  output logic [NREQ-1:0][n-1:0]      rdata,
  output logic [REG_AW-1:0]           Raddr1,
  output logic [REG_AW-1:0]           Raddr2,
  output logic                        w1,
  output logic                        w2,
  output logic [n-1:0]                Wdata1,
  output logic [n-1:0]                Wdata2,
  input  logic [n-1:0]                Rdata1,
  input  logic [n-1:0]                Rdata2
);

  logic [2:0]  ptr_q, ptr_d;
  rtag_t       tag1_q, tag1_d, tag2_q, tag2_d;

  logic [NREQ-1:0] req_v, mask_b;
  logic            a_found, b_found;
  logic [2:0]      a_idx, b_idx;
  logic            a_we, b_we;
  logic [REG_AW-1:0] a_addr, b_addr;
  logic [n-1:0]    a_wdata, b_wdata;
  port_sel_t       rsel [NREQ];

  // Nothing is granted while reset is held.
  assign req_v = reset ? '0 : req;

  rr_pick #(.NREQ(NREQ)) u_pick_a (
    .mask_i (req_v),
    .start_i(ptr_q),
    .found_o(a_found),
    .idx_o  (a_idx)
  );

  always_comb begin
    a_we    = 1'b0;
    a_addr  = '0;
    a_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (a_idx == 3'(i)) begin
        a_we    = req_we[i];
        a_addr  = req_addr[i];
        a_wdata = req_wdata[i];
      end
    end
  end

  // Slot B excludes slot A and anything hazarding on A's register (reads of r0 and read/read pairs are fine).
  always_comb begin
    mask_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask_b[i] = req_v[i] && (a_idx != 3'(i)) &&
                  !((req_addr[i] == a_addr) && (a_addr != '0) && (req_we[i] || a_we));
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick_b (
    .mask_i (mask_b),
    .start_i(wrap_inc(a_idx, NREQ)),
    .found_o(b_found),
    .idx_o  (b_idx)
  );

  always_comb begin
    b_we    = 1'b0;
    b_addr  = '0;
    b_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (b_idx == 3'(i)) begin
        b_we    = req_we[i];
        b_addr  = req_addr[i];
        b_wdata = req_wdata[i];
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = (a_found && (a_idx == 3'(i))) || (b_found && (b_idx == 3'(i)));
    end
  end

  assign Raddr1 = a_found ? a_addr  : '0;
  assign Wdata1 = a_found ? a_wdata : '0;
  assign w1     = a_found && a_we && (a_addr != '0);
  assign Raddr2 = b_found ? b_addr  : '0;
  assign Wdata2 = b_found ? b_wdata : '0;
  assign w2     = b_found && b_we && (b_addr != '0);

  always_comb begin
    ptr_d  = ptr_q;
    if (b_found)      ptr_d = wrap_inc(b_idx, NREQ);
    else if (a_found) ptr_d = wrap_inc(a_idx, NREQ);
    tag1_d = '{v: a_found && !a_we, idx: a_idx};
    tag2_d = '{v: b_found && !b_we, idx: b_idx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= 3'd0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  // Return tags route the port read data back to whoever was granted last cycle.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsel[i] = PORT_NONE;
      if (tag1_q.v && (tag1_q.idx == 3'(i)))      rsel[i] = PORT_1;
      else if (tag2_q.v && (tag2_q.idx == 3'(i))) rsel[i] = PORT_2;
      if (!reset) begin
        rvalid[i] = (rsel[i] != PORT_NONE);
        case (rsel[i])
          PORT_1:  rdata[i] = Rdata1;
          PORT_2:  rdata[i] = Rdata2;
          default: rdata[i] = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regs_port_arbiter.sv
// Self-checking bench: register-file model plus a read-return scoreboard.
module tb_regs_port_arbiter;

  localparam int N  = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0] req, req_we, gnt, rvalid;
  logic [NR-1:0][4:0] req_addr;
  logic [NR-1:0][N-1:0] req_wdata, rdata;
  logic [4:0] Raddr1, Raddr2;
  logic w1, w2;
  logic [N-1:0] Wdata1, Wdata2, Rdata1, Rdata2;

  logic [N-1:0] mem    [32];
  logic [N-1:0] shadow [32];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int           idx;
    logic [N-1:0] data;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  regs_port_arbiter #(.n(N), .NREQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .w1(w1), .w2(w2),
    .Wdata1(Wdata1), .Wdata2(Wdata2), .Rdata1(Rdata1), .Rdata2(Rdata2)
  );

  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 8'h11);
  end

  always @(posedge clk) begin
    if (w1) mem[Raddr1] <= Wdata1;
    if (w2) mem[Raddr2] <= Wdata2;
    Rdata1 <= (Raddr1 == 5'd0) ? 8'h00 : mem[Raddr1];
    Rdata2 <= (Raddr2 == 5'd0) ? 8'h00 : mem[Raddr2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] we,
                       input logic [3:0][4:0] a, input logic [3:0][7:0] wd);
    req       = r;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares last cycle's returns, the current grant, then queues this cycle's expected returns.
  task automatic settle_check(input logic use_exp, input logic [3:0] exp_g, input string tag);
    logic [3:0] g;
    logic [3:0] exp_rv;
    exp_t e;
    #1;
    exp_rv = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      exp_rv[e.idx] = 1'b1;
      chk({tag, " rdata"}, 32'(rdata[e.idx]), 32'(e.data));
    end
    chk({tag, " rvalid"}, 32'(rvalid), 32'(exp_rv));
    if (use_exp) chk({tag, " gnt"}, 32'(gnt), 32'(exp_g));
    g = use_exp ? exp_g : gnt;
    for (int i = 0; i < NR; i++) begin
      if (g[i] && !req_we[i]) begin
        e.idx  = i;
        e.data = (req_addr[i] == 5'd0) ? 8'h00 : shadow[req_addr[i]];
        sb.push_back(e);
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (g[i] && req_we[i] && (req_addr[i] != 5'd0)) shadow[req_addr[i]] = req_wdata[i];
    end
  endtask

  task automatic check_ports_zero(input string tag);
    chk({tag, " gnt"},    32'(gnt),    0);
    chk({tag, " rvalid"}, 32'(rvalid), 0);
    chk({tag, " rdata"},  32'(rdata),  0);
    chk({tag, " w"},      32'({w1, w2}), 0);
    chk({tag, " raddr"},  32'({Raddr1, Raddr2}), 0);
    chk({tag, " wdata"},  32'({Wdata1, Wdata2}), 0);
  endtask

  int miss3;
  logic [3:0] r;

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = 8'(i * 8'h11);
    reset = 1'b1;
    drive(4'b1111, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    tick();
    tick();
    #1;
    check_ports_zero("reset");

    // Round-robin over four non-conflicting reads.
    reset = 1'b0;
    settle_check(1'b1, 4'b0011, "rr1");
    chk("rr1 raddr1", 32'(Raddr1), 1);
    chk("rr1 raddr2", 32'(Raddr2), 2);
    tick();
    drive(4'b1100, 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, '0);
    settle_check(1'b1, 4'b1100, "rr2");
    chk("rr2 raddr1", 32'(Raddr1), 3);
    chk("rr2 raddr2", 32'(Raddr2), 4);
    tick();

    // Write/read hazard on r1: the write wins, the read follows.
    drive(4'b0011, 4'b0001, {5'd0, 5'd0, 5'd1, 5'd1}, {8'h0, 8'h0, 8'h0, 8'd11});
    settle_check(1'b1, 4'b0001, "haz");
    chk("haz w1", 32'(w1), 1);
    chk("haz wdata1", 32'(Wdata1), 11);
    chk("haz w2", 32'(w2), 0);
    tick();
    drive(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd1, 5'd0}, '0);
    settle_check(1'b1, 4'b0010, "haz2");
    tick();

    // Write to r0 is granted but never reaches the file.
    drive(4'b0100, 4'b0100, {5'd0, 5'd0, 5'd0, 5'd0}, {8'h0, 8'hFF, 8'h0, 8'h0});
    settle_check(1'b1, 4'b0100, "r0w");
    chk("r0w w1", 32'(w1), 0);
    tick();

    // Pointer sits at 3: slot A is req3, slot B wraps to req0 (read of r0).
    drive(4'b1001, 4'b0000, {5'd5, 5'd0, 5'd0, 5'd0}, '0);
    settle_check(1'b1, 4'b1001, "wrap");
    chk("wrap raddr1", 32'(Raddr1), 5);
    chk("wrap raddr2", 32'(Raddr2), 0);
    tick();

    // Two reads of the same register are both granted.
    drive(4'b0011, 4'b0000, {5'd0, 5'd0, 5'd2, 5'd2}, '0);
    settle_check(1'b1, 4'b0011, "rdrd");
    chk("rdrd raddr1", 32'(Raddr1), 2);
    chk("rdrd raddr2", 32'(Raddr2), 2);
    tick();

    // req3 held while the others toggle.
    miss3 = 0;
    for (int c = 0; c < 24; c++) begin
      r = {1'b1, 3'($urandom)};
      drive(r, 4'b0000, {5'd8, 5'd7, 5'd6, 5'd5}, '0);
      settle_check(1'b0, 4'b0000, "starve");
      chk("starve subset", 32'(gnt & ~req), 0);
      chk("starve count", $countones(gnt), ($countones(req) > 2) ? 2 : $countones(req));
      if (gnt[3]) miss3 = 0;
      else        miss3++;
      chk("starve bound", 32'(miss3 < 3), 1);
      tick();
    end
    drive(4'b0000, 4'b0000, '0, '0);
    settle_check(1'b1, 4'b0000, "drain1");
    tick();

    // Reset right after a read grant suppresses the return and clears the pointer.
    drive(4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd3}, '0);
    settle_check(1'b1, 4'b0001, "pre_rst");
    tick();
    reset = 1'b1;
    drive(4'b0011, 4'b0001, {5'd0, 5'd0, 5'd6, 5'd6}, {8'h0, 8'h0, 8'h0, 8'h5A});
    #1;
    check_ports_zero("mid_rst");
    sb.delete();
    tick();
    reset = 1'b0;
    settle_check(1'b1, 4'b0001, "post_rst");
    chk("post_rst w1", 32'(w1), 1);
    tick();
    drive(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd6, 5'd0}, '0);
    settle_check(1'b1, 4'b0010, "post_rst2");
    tick();
    drive(4'b0000, 4'b0000, '0, '0);
    settle_check(1'b1, 4'b0000, "drain2");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
